reg_bus_arbiter: RTL and testbench

- Two-requester arbiter sharing the single register-bus port of main_memory (i_addr/i_data/i_wr/o_data).
- Requester 0 is the host command decoder (UART/SPI); requester 1 is the autonomous channel-scan sequencer.
- Serialises register reads and writes, handles main_memory's one-cycle registered read latency, and returns read data with a single-cycle ack.
- Round-robin fairness when both request together.

---
 rtl/reg_bus_arbiter.sv | 166 ++++++++++++++++
 tb/tb_reg_bus_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_arbiter.sv
// Two-requester round-robin arbiter for the main_memory register port.
// Optional grant locking for read-modify-write sequences: define ARB_LOCK_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module reg_bus_arbiter #(
  parameter int ADDR_W = `ADDR_WIDTH,
  parameter int DATA_W = `DATA_WIDTH
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_m0_req,
  input  logic              i_m0_wr,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  input  logic              i_m0_lock,
  output logic              o_m0_ack,
  output logic [DATA_W-1:0] o_m0_rdata,
  input  logic              i_m1_req,
  input  logic              i_m1_wr,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_wdata,
  input  logic              i_m1_lock,
  output logic              o_m1_ack,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_wr,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_busy
);

`ifdef ARB_LOCK_EN
  localparam logic LOCK_EN = 1'b1;
`else
  localparam logic LOCK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, ACK} state_e;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                id_q, id_d;
  logic                wr_q, wr_d;
  logic                lock_q, lock_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                locked_q, locked_d;
  logic                holder_q, holder_d;
  logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;
  logic                gnt_valid;
  logic                gnt_id;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      wr_q         <= 1'b0;
      lock_q       <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      locked_q     <= 1'b0;
      holder_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      wr_q         <= wr_d;
      lock_q       <= lock_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      locked_q     <= locked_d;
      holder_q     <= holder_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    wr_d         = wr_q;
    lock_d       = lock_q;
    addr_d       = addr_q;
    data_d       = data_q;
    locked_d     = locked_q;
    holder_d     = holder_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    gnt_valid    = 1'b0;
    gnt_id       = 1'b0;
    o_wr         = 1'b0;
    o_addr       = '0;
    o_data       = '0;
    o_m0_ack     = 1'b0;
    o_m1_ack     = 1'b0;

    case (state_q)
      IDLE: begin
        // A lock holder is served exclusively; otherwise a tie goes to the
        // requester that did not win last time.
        if (locked_q) begin
          gnt_valid = holder_q ? i_m1_req : i_m0_req;
          gnt_id    = holder_q;
        end else if (i_m0_req && i_m1_req) begin
          gnt_valid = 1'b1;
          gnt_id    = ~last_grant_q;
        end else if (i_m0_req) begin
          gnt_valid = 1'b1;
          gnt_id    = 1'b0;
        end else if (i_m1_req) begin
          gnt_valid = 1'b1;
          gnt_id    = 1'b1;
        end
        if (gnt_valid) begin
          id_d         = gnt_id;
          wr_d         = gnt_id ? i_m1_wr    : i_m0_wr;
          addr_d       = gnt_id ? i_m1_addr  : i_m0_addr;
          data_d       = gnt_id ? i_m1_wdata : i_m0_wdata;
          lock_d       = LOCK_EN & (gnt_id ? i_m1_lock : i_m0_lock);
          last_grant_d = gnt_id;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        o_addr  = addr_q;
        o_data  = data_q;
        o_wr    = wr_q;
        state_d = wr_q ? ACK : RDWAIT;
      end
      RDWAIT: begin
        // main_memory registers its read, so data arrives one cycle after ISSUE.
        o_addr = addr_q;
        if (id_q) m1_rdata_d = i_rdata;
        else      m0_rdata_d = i_rdata;
        state_d = ACK;
      end
      ACK: begin
        o_m0_ack = ~id_q;
        o_m1_ack = id_q;
        if (lock_q) begin
          locked_d = 1'b1;
          holder_d = id_q;
        end else if (locked_q && (holder_q == id_q)) begin
          locked_d = 1'b0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_m0_rdata = m0_rdata_q;
  assign o_m1_rdata = m1_rdata_q;
  assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter: main_memory stand-in, queued requester drivers,
// a cycle-timed transaction model and a per-cycle output checker.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef CH_MUX_ENABLE
`define CH_MUX_ENABLE 8'h04
`endif
`ifndef CH_MUX_SELECTOR
`define CH_MUX_SELECTOR 8'h05
`endif

module tb_reg_bus_arbiter;
  localparam int AW = `ADDR_WIDTH;
  localparam int DW = `DATA_WIDTH;
  localparam logic [AW-1:0] CH_ENA = AW'(`CH_MUX_ENABLE);
  localparam logic [AW-1:0] CH_SEL = AW'(`CH_MUX_SELECTOR);

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          lock;
  } cmd_t;

  // ---------------- clock / reset / DUT ----------------
  logic          clk;
  logic          rst;
  logic [1:0]    req, wr, lock;
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic          o_m0_ack, o_m1_ack, o_wr, o_busy;
  logic [DW-1:0] o_m0_rdata, o_m1_rdata, o_data, mem_rdata;
  logic [AW-1:0] o_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  reg_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m0_req(req[0]), .i_m0_wr(wr[0]), .i_m0_addr(addr[0]), .i_m0_wdata(wdata[0]),
    .i_m0_lock(lock[0]), .o_m0_ack(o_m0_ack), .o_m0_rdata(o_m0_rdata),
    .i_m1_req(req[1]), .i_m1_wr(wr[1]), .i_m1_addr(addr[1]), .i_m1_wdata(wdata[1]),
    .i_m1_lock(lock[1]), .o_m1_ack(o_m1_ack), .o_m1_rdata(o_m1_rdata),
    .o_addr(o_addr), .o_data(o_data), .o_wr(o_wr), .i_rdata(mem_rdata), .o_busy(o_busy)
  );

  // main_memory stand-in: registered read, write on o_wr
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [3:0]    ch_ena;
  always @(posedge clk) begin
    if (o_wr) mem[o_addr] <= o_data;
    mem_rdata <= mem[o_addr];
  end
  assign ch_ena = mem[CH_ENA][3:0];

  // ---------------- bookkeeping ----------------
  int n_cmp, n_bad, cyc;
  int ack_id_log[$];
  int ack_cyc_log[$];
  cmd_t q0[$];
  cmd_t q1[$];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit            has_g, g_id, g_wr, m_last, m_locked, m_holder;
  int            g_cyc, free_cyc;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata;
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  logic [DW-1:0] exp_rdata [2];

  task automatic model_reset();
    has_g = 0; g_cyc = 0; g_id = 0; g_wr = 0; g_addr = '0; g_wdata = '0;
    free_cyc = cyc; m_last = 1; m_locked = 0; m_holder = 0;
    exp_q0.delete(); exp_q1.delete();
    exp_rdata[0] = '0; exp_rdata[1] = '0;
  endtask

  // Bus is free from free_cyc on; a transaction occupies its grant cycle plus
  // 2 (write) or 3 (read) busy cycles.
  task automatic model_decide();
    int w;
    if (rst || cyc < free_cyc) return;
    w = -1;
    if (m_locked) begin
      if (req[m_holder]) w = int'(m_holder);
    end else if (req[0] && req[1]) w = m_last ? 0 : 1;
    else if (req[0]) w = 0;
    else if (req[1]) w = 1;
    if (w < 0) return;
    has_g = 1; g_cyc = cyc; g_id = w[0]; g_wr = wr[w];
    g_addr = addr[w]; g_wdata = wdata[w];
    free_cyc = cyc + (g_wr ? 3 : 4);
    m_last = w[0];
    if (!g_wr) begin
      if (w == 0) exp_q0.push_back(ref_mem[g_addr]);
      else        exp_q1.push_back(ref_mem[g_addr]);
    end
`ifdef ARB_LOCK_EN
    if (lock[w]) begin
      m_locked = 1; m_holder = w[0];
    end else if (m_locked && m_holder == w[0]) begin
      m_locked = 0;
    end
`endif
  endtask

  // ---------------- per-cycle checker ----------------
  int            k;
  bit            e_busy, e_wr, e_ack;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;

  always @(negedge clk) begin
    if (!rst) begin
      k      = cyc - g_cyc;
      e_busy = has_g && (cyc > g_cyc) && (cyc < free_cyc);
      e_wr   = e_busy && (k == 1) && g_wr;
      e_addr = (e_busy && (k == 1 || (k == 2 && !g_wr))) ? g_addr : '0;
      e_data = (e_busy && k == 1) ? g_wdata : '0;
      e_ack  = e_busy && (k == (g_wr ? 2 : 3));
      if (e_wr) ref_mem[g_addr] = g_wdata;
      if (e_ack && !g_wr) begin
        if (g_id == 0 && exp_q0.size() > 0) exp_rdata[0] = exp_q0.pop_front();
        if (g_id == 1 && exp_q1.size() > 0) exp_rdata[1] = exp_q1.pop_front();
      end
      cmp("o_busy",     32'(o_busy),     32'(e_busy));
      cmp("o_wr",       32'(o_wr),       32'(e_wr));
      cmp("o_addr",     32'(o_addr),     32'(e_addr));
      cmp("o_data",     32'(o_data),     32'(e_data));
      cmp("o_m0_ack",   32'(o_m0_ack),   32'(e_ack && g_id == 0));
      cmp("o_m1_ack",   32'(o_m1_ack),   32'(e_ack && g_id == 1));
      cmp("o_m0_rdata", 32'(o_m0_rdata), 32'(exp_rdata[0]));
      cmp("o_m1_rdata", 32'(o_m1_rdata), 32'(exp_rdata[1]));
    end
  end

  // ---------------- driver tasks ----------------
  function automatic cmd_t mk(input logic w, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic l);
    cmd_t c;
    c.wr = w; c.addr = a; c.wdata = d; c.lock = l;
    return c;
  endfunction

  task automatic push_cmd(input int i, input cmd_t c);
    if (i == 0) q0.push_back(c);
    else        q1.push_back(c);
  endtask

  // Hold the command until ack; at ack either chain the next queued command
  // (back-to-back) or drop req.
  task automatic drive_req(input int i);
    logic ack_i;
    cmd_t c;
    bit   have;
    ack_i = (i == 0) ? o_m0_ack : o_m1_ack;
    if (req[i] && !ack_i) return;
    have = 0;
    if (i == 0 && q0.size() > 0) begin c = q0.pop_front(); have = 1; end
    if (i == 1 && q1.size() > 0) begin c = q1.pop_front(); have = 1; end
    if (have) begin
      req[i] = 1'b1; wr[i] = c.wr; addr[i] = c.addr; wdata[i] = c.wdata; lock[i] = c.lock;
    end else begin
      req[i] = 1'b0;
    end
  endtask

  task automatic gen_random();
    logic ack_i;
    int   qs;
    for (int i = 0; i < 2; i++) begin
      ack_i = (i == 0) ? o_m0_ack : o_m1_ack;
      qs    = (i == 0) ? q0.size() : q1.size();
      if (qs == 0 && ((req[i] && ack_i && $urandom_range(0, 1) == 1) ||
                      (!req[i] && $urandom_range(0, 3) == 0)))
        push_cmd(i, mk(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                       DW'($urandom_range(0, 255)), 1'($urandom_range(0, 3) == 0)));
    end
  endtask

  task automatic cycle(input bit rnd);
    @(posedge clk); #1;
    cyc++;
    if (!rst) begin
      if (o_m0_ack) begin ack_id_log.push_back(0); ack_cyc_log.push_back(cyc); end
      if (o_m1_ack) begin ack_id_log.push_back(1); ack_cyc_log.push_back(cyc); end
      if (rnd) gen_random();
      drive_req(0);
      drive_req(1);
      model_decide();
    end
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1;
    rst = 1'b1; req = '0; q0.delete(); q1.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    ack_id_log.delete(); ack_cyc_log.delete();
  endtask

  task automatic check_ack(input int j, input int exp_id, input int exp_cyc);
    if (j >= ack_id_log.size()) begin
      cmp("ack_count", 32'(ack_id_log.size()), 32'(j + 1));
    end else begin
      cmp("ack_id",    32'(ack_id_log[j]),  32'(exp_id));
      cmp("ack_cycle", 32'(ack_cyc_log[j]), 32'(exp_cyc));
    end
  endtask

  // ---------------- stimulus ----------------
  int t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    rst = 1'b1; req = '0; wr = '0; lock = '0;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    for (int i = 0; i < (1 << AW); i++) begin mem[i] = '0; ref_mem[i] = '0; end
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    cmp("rst_o_wr",     32'(o_wr),       32'd0);
    cmp("rst_o_busy",   32'(o_busy),     32'd0);
    cmp("rst_o_addr",   32'(o_addr),     32'd0);
    cmp("rst_o_data",   32'(o_data),     32'd0);
    cmp("rst_acks",     32'({o_m0_ack, o_m1_ack}), 32'd0);
    cmp("rst_m0_rdata", 32'(o_m0_rdata), 32'd0);
    cmp("rst_m1_rdata", 32'(o_m1_rdata), 32'd0);
    rst = 1'b0;
    model_reset();

    // m0 write CH_MUX_ENABLE=5: o_wr at cycle 1, ack at cycle 2
    push_cmd(0, mk(1'b1, CH_ENA, DW'(5), 1'b0));
    cycle(0); t = cyc;
    cmp("t1_idle_busy", 32'(o_busy), 32'd0);
    cycle(0);
    cmp("t1_o_wr",   32'(o_wr),   32'd1);
    cmp("t1_o_addr", 32'(o_addr), 32'(CH_ENA));
    cmp("t1_o_data", 32'(o_data), 32'd5);
    cycle(0);
    cmp("t1_m0_ack", 32'(o_m0_ack), 32'd1);
    cmp("t1_o_wr_off", 32'(o_wr), 32'd0);
    cmp("t1_ch_ena", 32'(ch_ena), 32'h5);

    // m1 read CH_MUX_ENABLE: ack at cycle 3 with 5, m0 rdata untouched
    push_cmd(1, mk(1'b0, CH_ENA, DW'(0), 1'b0));
    cycle(0); t = cyc;
    repeat (3) cycle(0);
    cmp("t2_m1_ack",   32'(o_m1_ack),   32'd1);
    cmp("t2_m1_rdata", 32'(o_m1_rdata), 32'h5);
    cmp("t2_m0_rdata", 32'(o_m0_rdata), 32'h0);
    cycle(0);

    // both read, held high from reset: m0, m1, m0, m1 with acks 4 apart
    reset_pulse();
    push_cmd(0, mk(1'b0, CH_ENA, DW'(0), 1'b0)); push_cmd(0, mk(1'b0, AW'(1), DW'(0), 1'b0));
    push_cmd(1, mk(1'b0, AW'(2), DW'(0), 1'b0)); push_cmd(1, mk(1'b0, CH_ENA, DW'(0), 1'b0));
    cycle(0); t = cyc;
    repeat (17) cycle(0);
    check_ack(0, 0, t + 3);
    check_ack(1, 1, t + 7);
    check_ack(2, 0, t + 11);
    check_ack(3, 1, t + 15);
    cmp("t3_m0_rdata", 32'(o_m0_rdata), 32'h0);
    cmp("t3_m1_rdata", 32'(o_m1_rdata), 32'h5);

    // m1 write CH_MUX_SELECTOR=3 aborted by reset during ISSUE
    reset_pulse();
    push_cmd(1, mk(1'b1, CH_SEL, DW'(3), 1'b0));
    cycle(0);
    cycle(0);
    cmp("t4_issue_wr", 32'(o_wr), 32'd1);
    #2;
    rst = 1'b1; req = '0; q0.delete(); q1.delete();
    #1;
    cmp("t4_rst_o_wr",   32'(o_wr),     32'd0);
    cmp("t4_rst_o_busy", 32'(o_busy),   32'd0);
    cmp("t4_rst_ack",    32'(o_m1_ack), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    repeat (3) cycle(0);
    cmp("t4_no_ack", 32'(ack_id_log.size()), 32'd0);
    cmp("t4_sel_unwritten", 32'(mem[CH_SEL]), 32'd0);
    push_cmd(0, mk(1'b1, CH_SEL, DW'(1), 1'b0));
    push_cmd(1, mk(1'b1, CH_SEL, DW'(2), 1'b0));
    cycle(0); t = cyc;
    repeat (7) cycle(0);
    check_ack(0, 0, t + 2);
    check_ack(1, 1, t + 5);
    cmp("t4_sel_final", 32'(mem[CH_SEL]), 32'd2);

    // m1 locked read-modify-write with m0 waiting
    reset_pulse();
    push_cmd(1, mk(1'b0, CH_ENA, DW'(0), 1'b1));
    push_cmd(1, mk(1'b1, CH_ENA, DW'(9), 1'b0));
    cycle(0); t = cyc;
    push_cmd(0, mk(1'b1, CH_SEL, DW'(7), 1'b0));
    repeat (12) cycle(0);
    check_ack(0, 1, t + 3);
`ifdef ARB_LOCK_EN
    check_ack(1, 1, t + 6);
    check_ack(2, 0, t + 9);
`else
    check_ack(1, 0, t + 6);
    check_ack(2, 1, t + 9);
`endif

    // randomized traffic against the model
    reset_pulse();
    repeat (3000) cycle(1);
    repeat (30) cycle(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
